// File: rtl/output_drainer_pkg.sv
// rtl/output_drainer_pkg.sv - shared block geometry and drainer state encoding
package output_drainer_pkg;

    // Geometry shared with the output filler so both ends agree on block layout.
    localparam int OD_PIX_W     = 8;
    localparam int OD_WORD_W    = 64;
    localparam int OD_NUM_WORDS = 40;
    localparam int OD_IDX_W     = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_e;

endpackage

// File: rtl/output_drainer_drain_counter.sv
// rtl/output_drainer_drain_counter.sv - word index counter with clear and terminal-count flag
module drain_counter #(
    parameter int NUM_WORDS = 40,
    parameter int IDX_W     = 6
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             tc_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // Clear wins over increment; wrapping at the terminal count keeps the index in range.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;
    assign tc_o  = (idx_q == LAST_IDX);

endmodule

// File: rtl/output_drainer.sv
// rtl/output_drainer.sv - latches one interpolated block and streams it out word by word
module output_drainer
    import output_drainer_pkg::*;
#(
    parameter int WORD_W    = OD_WORD_W,
    parameter int NUM_WORDS = OD_NUM_WORDS,
    parameter int IDX_W     = OD_IDX_W
) (
    input  logic                          clock,
    input  logic                          reset_L,
    input  logic                          abort,
    input  logic                          blk_valid,
    input  logic [WORD_W*NUM_WORDS-1:0]   blk_in,
    output logic                          blk_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_first,
    output logic                          out_last,
    output logic                          done
);

    drain_state_e      state_q;
    drain_state_e      state_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [WORD_W-1:0] out_data_q;
    logic [WORD_W-1:0] out_data_d;
    logic [WORD_W-1:0] buf_q [NUM_WORDS];

    logic              cnt_clr;
    logic              cnt_inc;
    logic [IDX_W-1:0]  idx;
    logic              tc;
    logic              word_hs;
    logic              capture;

    drain_counter #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_drain_counter (
        .clock   (clock),
        .reset_L (reset_L),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .idx_o   (idx),
        .tc_o    (tc)
    );

    assign out_first = out_valid_q & (idx == '0);
    assign out_last  = out_valid_q & tc;
    assign word_hs   = out_valid_q & out_ready;

    // Accepting on the final handshake lets a new block follow with no bubble.
    assign blk_ready = ~abort & ((state_q == ST_IDLE) |
                                 ((state_q == ST_STREAM) & out_last & out_ready));
    assign capture   = blk_valid & blk_ready;

    // done marks the final handshake itself, so it is qualified by the live out_ready.
    assign done      = ~abort & word_hs & tc;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_clr     = 1'b1;
        end else if (state_q == ST_IDLE) begin
            if (capture) begin
                state_d     = ST_STREAM;
                out_valid_d = 1'b1;
                out_data_d  = blk_in[WORD_W-1:0];
                cnt_clr     = 1'b1;
            end
        end else if (word_hs) begin
            if (tc) begin
                cnt_clr = 1'b1;
                if (capture) begin
                    out_data_d = blk_in[WORD_W-1:0];
                end else begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end else begin
                cnt_inc    = 1'b1;
                out_data_d = buf_q[idx + IDX_W'(1)];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                buf_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                buf_q[k] <= blk_in[k*WORD_W +: WORD_W];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = idx;

endmodule

// File: tb/tb_output_drainer.sv
// tb/tb_output_drainer.sv - randomized self-checking bench for output_drainer
module tb_output_drainer;

    localparam int W  = 64;
    localparam int N  = 40;
    localparam int IW = 6;

    logic            clock = 1'b0;
    logic            reset_L;
    logic            abort;
    logic            blk_valid;
    logic [W*N-1:0]  blk_in;
    logic            blk_ready;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_idx;
    logic            out_first;
    logic            out_last;
    logic            done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] blk_a [N];
    logic [W-1:0] blk_b [N];

    output_drainer dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .abort     (abort),
        .blk_valid (blk_valid),
        .blk_in    (blk_in),
        .blk_ready (blk_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_first (out_first),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [W-1:0] w [N]);
        for (int k = 0; k < N; k++) blk_in[k*W +: W] = w[k];
    endtask

    task automatic rand_fill(output logic [W-1:0] w [N]);
        for (int k = 0; k < N; k++) w[k] = {$urandom, $urandom};
    endtask

    task automatic test_reset;
        reset_L = 1'b0; abort = 1'b0; blk_valid = 1'b0; out_ready = 1'b0; blk_in = '0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({out_valid, out_idx, out_first, out_last, done, out_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_idx, out_first, out_last, done, out_data});
        end
        reset_L = 1'b1;
        #1;
        total++;
        if ({blk_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release got=%b exp=10", {blk_ready, out_valid});
        end
    endtask

    task automatic test_basic;
        logic [W+10:0] got_t, exp_t;
        for (int k = 0; k < N; k++) blk_a[k] = {8{8'(k)}};
        present(blk_a);
        blk_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++;
        if (blk_ready !== 1'b1) begin
            bad++; $display("FAIL basic_accept_ready got=%b exp=1", blk_ready);
        end
        tick;
        blk_valid = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            got_t = {out_valid, blk_ready, done, out_idx, out_first, out_last, out_data};
            exp_t = {1'b1, k == N-1, k == N-1, IW'(k), k == 0, k == N-1, blk_a[k]};
            total++;
            if (got_t !== exp_t) begin
                bad++; $display("FAIL basic_word%0d got=%h exp=%h", k, got_t, exp_t);
            end
            tick;
        end
        total++;
        if ({out_valid, blk_ready} !== 2'b01) begin
            bad++; $display("FAIL basic_end got=%b exp=01", {out_valid, blk_ready});
        end
    endtask

    task automatic test_backpressure;
        int got = 0;
        int cyc = 0;
        logic [W+9:0] got_t, exp_t;
        rand_fill(blk_a);
        present(blk_a);
        blk_valid = 1'b1; out_ready = 1'b0;
        tick;
        blk_valid = 1'b0;
        while (got < N && cyc < 400) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            got_t = {out_valid, blk_ready, done, out_idx, out_first, out_last, out_data};
            exp_t = {1'b1, out_ready && got == N-1, out_ready && got == N-1,
                     IW'(got), got == 0, got == N-1, blk_a[got]};
            total++;
            if (got_t !== exp_t) begin
                bad++; $display("FAIL bp_cycle%0d got=%h exp=%h", cyc, got_t, exp_t);
            end
            if (out_ready) got++;
            cyc++;
            tick;
        end
        total++;
        if (got != N || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_complete got=%0d/%b exp=%0d/0", got, out_valid, N);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int ndone = 0;
        logic [W+8:0] got_t, exp_t;
        rand_fill(blk_a);
        rand_fill(blk_b);
        present(blk_a);
        blk_valid = 1'b1; out_ready = 1'b1;
        tick;
        present(blk_b);
        for (int c = 0; c < 2*N; c++) begin
            if (c == N) blk_valid = 1'b0;
            #1;
            got_t = {out_valid, blk_ready, out_idx, out_first, out_last, out_data};
            exp_t = {1'b1, c % N == N-1, IW'(c % N), c % N == 0, c % N == N-1,
                     (c < N) ? blk_a[c] : blk_b[c-N]};
            total++;
            if (got_t !== exp_t) begin
                bad++; $display("FAIL b2b_cycle%0d got=%h exp=%h", c, got_t, exp_t);
            end
            if (done === 1'b1) ndone++;
            tick;
        end
        total++;
        if (ndone != 2 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_done_count got=%0d/%b exp=2/0", ndone, out_valid);
        end
    endtask

    task automatic test_isolation;
        int got = 0;
        int cyc = 0;
        logic [W+6:0] got_t, exp_t;
        rand_fill(blk_a);
        present(blk_a);
        blk_valid = 1'b1; out_ready = 1'b0;
        tick;
        blk_valid = 1'b0;
        blk_in = '1;
        while (got < N && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            got_t = {out_valid, out_idx, out_data};
            exp_t = {1'b1, IW'(got), blk_a[got]};
            total++;
            if (got_t !== exp_t) begin
                bad++; $display("FAIL iso_cycle%0d got=%h exp=%h", cyc, got_t, exp_t);
            end
            if (out_ready) got++;
            cyc++;
            tick;
        end
        total++;
        if (got != N) begin
            bad++; $display("FAIL iso_timeout got=%0d exp=%0d", got, N);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort;
        int ndone = 0;
        logic [W+6:0] got_t, exp_t;
        rand_fill(blk_a);
        rand_fill(blk_b);
        present(blk_a);
        blk_valid = 1'b1; out_ready = 1'b1;
        tick;
        blk_valid = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            got_t = {out_valid, out_idx, out_data};
            exp_t = {1'b1, IW'(k), blk_a[k]};
            total++;
            if (got_t !== exp_t) begin
                bad++; $display("FAIL abort_pre%0d got=%h exp=%h", k, got_t, exp_t);
            end
            if (k < 17) tick;
        end
        present(blk_b);
        blk_valid = 1'b1; abort = 1'b1;
        #1;
        total++;
        if ({blk_ready, done} !== 2'b00) begin
            bad++; $display("FAIL abort_ready got=%b exp=00", {blk_ready, done});
        end
        tick;
        abort = 1'b0; blk_valid = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({out_valid, out_idx, done} !== '0) begin
                bad++; $display("FAIL abort_idle%0d got=%h exp=0", c, {out_valid, out_idx, done});
            end
            tick;
        end
        blk_valid = 1'b1;
        #1;
        total++;
        if (blk_ready !== 1'b1) begin
            bad++; $display("FAIL abort_reaccept got=%b exp=1", blk_ready);
        end
        tick;
        blk_valid = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            got_t = {out_valid, out_idx, out_data};
            exp_t = {1'b1, IW'(k), blk_b[k]};
            total++;
            if (got_t !== exp_t) begin
                bad++; $display("FAIL abort_post%0d got=%h exp=%h", k, got_t, exp_t);
            end
            if (done === 1'b1) ndone++;
            tick;
        end
        total++;
        if (ndone != 1) begin
            bad++; $display("FAIL abort_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_async_reset;
        rand_fill(blk_a);
        present(blk_a);
        blk_valid = 1'b1; out_ready = 1'b1;
        tick;
        blk_valid = 1'b0;
        repeat (25) tick;
        total++;
        if ({out_valid, out_idx, out_data} !== {1'b1, IW'(25), blk_a[25]}) begin
            bad++; $display("FAIL rst_pre got=%h exp=%h", {out_valid, out_idx, out_data}, {1'b1, IW'(25), blk_a[25]});
        end
        #2;
        reset_L = 1'b0;
        #1;
        total++;
        if ({out_valid, out_idx, out_first, out_last, done, out_data} !== '0) begin
            bad++; $display("FAIL rst_async got=%h exp=0", {out_valid, out_idx, out_first, out_last, done, out_data});
        end
        @(posedge clock);
        #3;
        reset_L = 1'b1;
        #1;
        total++;
        if ({blk_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL rst_release got=%b exp=10", {blk_ready, out_valid});
        end
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_discard got=%b exp=0", out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_isolation;
        test_abort;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
